bilstm_step_scheduler: RTL

// - Time-multiplexes one shared LSTM cell datapath between forward and backward directions over a T-step window.
// - Sits between the inertial control unit and the LSTM cell: consumes start_bilstm, issues one cell job per (direction, timestep), writes each hidden vector to the concat buffer, then pulses done_store_concat for the FC stages.
// - Issue order is interleaved: F t0, B t(T-1), F t1, B t(T-2), ..., F t(T-1), B t0.

---
 rtl/bilstm_step_scheduler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/bilstm_step_scheduler.sv
// ---------------------------------------------------------------------------
// bilstm_step_scheduler
//
// Purpose:
//   Shares one LSTM cell datapath between the forward and backward passes of
//   a bidirectional LSTM over a T_STEPS-long window. Jobs are issued
//   interleaved: F t0, B t(T-1), F t1, B t(T-2), ..., F t(T-1), B t0. Each
//   finished hidden vector is written to the concat buffer at {t, dir}. When
//   all 2*T_STEPS jobs are stored, done_store_concat pulses once.
//
// Ports:
//   clk                in   clock, rising edge
//   rst                in   asynchronous, active-high reset
//   start_bilstm       in   1-cycle pulse, begins a window (ignored when busy)
//   cell_done          in   1-cycle pulse from the cell, accepted only in WAIT
//   cell_start         out  1-cycle pulse, launch a cell job
//   cell_dir           out  0 = forward, 1 = backward (held for the whole job)
//   cell_t             out  timestep index of the current job
//   cell_first         out  with cell_start on the first job of each direction
//   store_we           out  1-cycle concat buffer write strobe
//   store_addr         out  concat address {cell_t, cell_dir}
//   done_store_concat  out  1-cycle pulse, whole window stored
//   busy               out  high in every state except IDLE
//   timeout_err        out  sticky WAIT timeout flag (BILSTM_SCHED_TIMEOUT_EN)
//
// Configuration:
//   BILSTM_SCHED_TIMEOUT_EN  when defined, WAIT is bounded to TIMEOUT cycles;
//                            on expiry timeout_err is set and the FSM aborts
//                            to IDLE without storing.
// ---------------------------------------------------------------------------
module bilstm_step_scheduler #(
    parameter int T_STEPS = 10,
    parameter int TW      = $clog2(T_STEPS),
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_bilstm,
    input  logic          cell_done,
    output logic          cell_start,
    output logic          cell_dir,
    output logic [TW-1:0] cell_t,
    output logic          cell_first,
    output logic          store_we,
    output logic [TW:0]   store_addr,
    output logic          done_store_concat,
    output logic          busy
`ifdef BILSTM_SCHED_TIMEOUT_EN
    ,
    output logic          timeout_err
`endif
);

    if (T_STEPS < 2 || TIMEOUT < 1) begin : g_param_check
        $error("bilstm_step_scheduler: T_STEPS must be >= 2 and TIMEOUT >= 1");
    end

    localparam int CW = $clog2(2 * T_STEPS);
    localparam logic [CW-1:0] LAST_JOB = CW'(2 * T_STEPS - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(T_STEPS - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] STORE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] fwd_t_q, fwd_t_d;
    logic [TW-1:0] bwd_t_q, bwd_t_d;
    logic          dir_q,   dir_d;
    logic [CW-1:0] count_q, count_d;

`ifdef BILSTM_SCHED_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        // NOTE: every next-state signal takes its held value first, so no
        // path through the case statement can infer a latch.
        state_d = state_q;
        fwd_t_d = fwd_t_q;
        bwd_t_d = bwd_t_q;
        dir_d   = dir_q;
        count_d = count_q;
`ifdef BILSTM_SCHED_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_bilstm) begin
                    fwd_t_d = '0;
                    bwd_t_d = T_LAST;
                    dir_d   = 1'b0;
                    count_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
`ifdef BILSTM_SCHED_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (cell_done) begin
                    state_d = STORE;
                end
`ifdef BILSTM_SCHED_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
`endif
            end
            STORE: begin
                // Each counter stops at its final timestep; the last job of a
                // direction leaves it in range instead of wrapping.
                if (!dir_q) begin
                    if (fwd_t_q != T_LAST) fwd_t_d = fwd_t_q + TW'(1);
                end else begin
                    if (bwd_t_q != '0) bwd_t_d = bwd_t_q - TW'(1);
                end
                dir_d   = ~dir_q;
                count_d = count_q + CW'(1);
                state_d = (count_q == LAST_JOB) ? DONE : ISSUE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values of the others.
        if (rst) begin
            state_q <= IDLE;
            fwd_t_q <= '0;
            bwd_t_q <= T_LAST;
            dir_q   <= 1'b0;
            count_q <= '0;
`ifdef BILSTM_SCHED_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            fwd_t_q <= fwd_t_d;
            bwd_t_q <= bwd_t_d;
            dir_q   <= dir_d;
            count_q <= count_d;
`ifdef BILSTM_SCHED_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    // Job descriptor is only driven while a job is in flight; outside it the
    // outputs read zero so IDLE/DONE look identical to reset.
    logic job_active;
    assign job_active = (state_q == ISSUE) || (state_q == WAIT) || (state_q == STORE);

    assign cell_start        = (state_q == ISSUE);
    assign cell_first        = (state_q == ISSUE) && (count_q < CW'(2));
    assign cell_dir          = job_active & dir_q;
    assign cell_t            = job_active ? (dir_q ? bwd_t_q : fwd_t_q) : '0;
    assign store_we          = (state_q == STORE);
    assign store_addr        = {cell_t, cell_dir};
    assign done_store_concat = (state_q == DONE);
    assign busy              = (state_q != IDLE);
`ifdef BILSTM_SCHED_TIMEOUT_EN
    assign timeout_err       = timeout_err_q;
`endif

endmodule
